// File: rtl/dac_output_pkg.sv
// Shared defaults and derived constants for the DAC output stage.
package dac_output_pkg;

  localparam int DEF_DATA_IN_W    = 64;
  localparam int DEF_DAC_W        = 14;
  localparam int DEF_MAX_LOG2_AVG = 8;

  // Holding up to 2^MAX_LOG2_AVG full-scale samples needs MAX_LOG2_AVG guard bits.
  function automatic int acc_width(input int data_w, input int max_log2);
    return data_w + max_log2;
  endfunction

  localparam int DEF_ACC_W    = acc_width(DEF_DATA_IN_W, DEF_MAX_LOG2_AVG);
  localparam int DAC_MIDSCALE = 2 ** (DEF_DAC_W - 1);

endpackage

// File: rtl/dac_saturator.sv
// Stage 2: clip the averaged value to the DAC range, convert to offset binary, register it.
module dac_saturator #(
  parameter int IN_W  = 72,
  parameter int DAC_W = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_vld,
  input  logic signed [IN_W-1:0]  i_data,
  output logic [DAC_W-1:0]        o_data,
  output logic                    o_vld,
  output logic                    o_clip
);

  localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((1 << (DAC_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_LO = ~SAT_HI;
  localparam logic [DAC_W-1:0]       MID    = {1'b1, {(DAC_W-1){1'b0}}};

  // Returns {clipped, offset_binary_code}; adding midscale is an MSB flip.
  function automatic logic [DAC_W:0] sat_ob(input logic signed [IN_W-1:0] v);
    if (v > SAT_HI)
      return {1'b1, {DAC_W{1'b1}}};
    else if (v < SAT_LO)
      return {1'b1, {DAC_W{1'b0}}};
    else
      return {1'b0, v[DAC_W-1:0] ^ MID};
  endfunction

  logic [DAC_W:0]   w_res;
  logic [DAC_W-1:0] r_data;
  logic             r_vld;
  logic             r_clip;

  assign w_res = sat_ob(i_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= MID;
      r_vld  <= 1'b0;
      r_clip <= 1'b0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_data <= w_res[DAC_W-1:0];
        r_clip <= w_res[DAC_W];
      end
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;
  assign o_clip = r_clip;

endmodule

// File: rtl/dac_output_stage.sv
// Block-averaging, gain-shifting DAC output stage with saturation to offset binary.
// Optional saturation counter enabled by macro DAC_OUTPUT_SAT_COUNT_EN.
module dac_output_stage
  import dac_output_pkg::*;
#(
  parameter int DATA_IN_W    = DEF_DATA_IN_W,
  parameter int DAC_W        = DEF_DAC_W,
  parameter int MAX_LOG2_AVG = DEF_MAX_LOG2_AVG
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic signed [DATA_IN_W-1:0] data_in,
  input  logic                        data_in_valid,
  input  logic [3:0]                  log2_avg,
  input  logic [5:0]                  shift,
  input  logic                        clear_sat,
  output logic [DAC_W-1:0]            dac_data,
  output logic                        dac_data_valid,
  output logic [31:0]                 sat_count
);

  localparam int ACC_W = acc_width(DATA_IN_W, MAX_LOG2_AVG);
  localparam int CNT_W = MAX_LOG2_AVG + 1;
  localparam int SH_W  = $clog2(MAX_LOG2_AVG + 64);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_s1;
  logic                    r_s1_vld;
  logic [CNT_W-1:0]        r_cnt;
  logic [3:0]              r_l;
  logic [5:0]              r_shift;

  logic                    w_accept;
  logic                    w_first;
  logic                    w_last;
  logic [3:0]              w_l_in;
  logic [3:0]              w_l;
  logic [5:0]              w_shift;
  logic [CNT_W-1:0]        w_pow;
  logic [SH_W-1:0]         w_tot;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shifted;
  logic                    w_vld;
  logic                    w_clip;

  assign w_accept  = enable & data_in_valid;
  assign w_first   = (r_cnt == '0);
  assign w_l_in    = (log2_avg > 4'(MAX_LOG2_AVG)) ? 4'(MAX_LOG2_AVG) : log2_avg;
  // The first sample of a block sees the live settings; later samples use the latched copy.
  assign w_l       = w_first ? w_l_in : r_l;
  assign w_shift   = w_first ? shift : r_shift;
  assign w_pow     = CNT_W'(1) << w_l;
  assign w_last    = (r_cnt == (w_pow - 1'b1));
  assign w_ext     = {{MAX_LOG2_AVG{data_in[DATA_IN_W-1]}}, data_in};
  assign w_sum     = r_acc + w_ext;
  assign w_tot     = SH_W'(w_l) + SH_W'(w_shift);
  assign w_shifted = w_sum >>> w_tot;

  // Stage 0/1: accumulate the block, capture the shifted sum on its last sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_s1     <= '0;
      r_s1_vld <= 1'b0;
      r_l      <= '0;
      r_shift  <= '0;
    end else if (!enable) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= 1'b0;
      if (w_accept) begin
        if (w_first) begin
          r_l     <= w_l_in;
          r_shift <= shift;
        end
        if (w_last) begin
          r_s1     <= w_shifted;
          r_s1_vld <= 1'b1;
          r_acc    <= '0;
          r_cnt    <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Stage 2: saturation and offset-binary conversion; a result pending while enable is low is dropped
  dac_saturator #(
    .IN_W  (ACC_W),
    .DAC_W (DAC_W)
  ) u_sat (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_vld  (r_s1_vld & enable),
    .i_data (r_s1),
    .o_data (dac_data),
    .o_vld  (w_vld),
    .o_clip (w_clip)
  );

  assign dac_data_valid = w_vld;

`ifdef DAC_OUTPUT_SAT_COUNT_EN
  logic [31:0] r_sat_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_sat_count <= '0;
    else if (clear_sat)
      r_sat_count <= '0;
    else if (w_vld && w_clip && !(&r_sat_count))
      r_sat_count <= r_sat_count + 1'b1;
  end

  assign sat_count = r_sat_count;
`else
  logic w_unused;
  assign w_unused  = clear_sat ^ w_clip;
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_dac_output_stage.sv
// Self-checking bench for dac_output_stage: vector table plus directed multi-cycle sequences.
module tb_dac_output_stage;

`ifdef DAC_OUTPUT_SAT_COUNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic signed [63:0] data_in = '0;
  logic               data_in_valid = 1'b0;
  logic [3:0]         log2_avg = '0;
  logic [5:0]         shift = '0;
  logic               clear_sat = 1'b0;
  logic [13:0]        dac_data;
  logic               dac_data_valid;
  logic [31:0]        sat_count;

  dac_output_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .log2_avg       (log2_avg),
    .shift          (shift),
    .clear_sat      (clear_sat),
    .dac_data       (dac_data),
    .dac_data_valid (dac_data_valid),
    .sat_count      (sat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  typedef struct {
    longint   din;
    bit [5:0] sh;
    int       exp;
    bit       clip;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dac_data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=%0d expected=no_pulse", dac_data);
      end else begin
        chk("dac_data", 64'(dac_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input longint v);
    @(negedge clk);
    data_in       = v;
    data_in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_in_valid = 1'b0;
    end
  endtask

  initial begin
    int clips;
    tbl[0]  = '{100,                    6'd0,  8292,  1'b0};
    tbl[1]  = '{-100,                   6'd0,  8092,  1'b0};
    tbl[2]  = '{0,                      6'd0,  8192,  1'b0};
    tbl[3]  = '{8191,                   6'd0,  16383, 1'b0};
    tbl[4]  = '{8192,                   6'd0,  16383, 1'b1};
    tbl[5]  = '{-8192,                  6'd0,  0,     1'b0};
    tbl[6]  = '{-8193,                  6'd0,  0,     1'b1};
    tbl[7]  = '{-161,                   6'd4,  8181,  1'b0};
    tbl[8]  = '{161,                    6'd4,  8202,  1'b0};
    tbl[9]  = '{-1,                     6'd1,  8191,  1'b0};
    tbl[10] = '{64'sd1099511627776,     6'd30, 9216,  1'b0};
    tbl[11] = '{64'shC000000000000000,  6'd63, 8191,  1'b0};
    tbl[12] = '{64'sh7FFFFFFFFFFFFFFF,  6'd63, 8192,  1'b0};
    tbl[13] = '{20000,                  6'd0,  16383, 1'b1};
    tbl[14] = '{-20000,                 6'd0,  0,     1'b1};
    tbl[15] = '{32764,                  6'd2,  16383, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_dac_data", 64'(dac_data), 64'd8192);
    chk("reset_valid", 64'(dac_data_valid), 64'd0);
    chk("reset_sat_count", 64'(sat_count), 64'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    idle(4);
    chk("idle_no_pulse", 64'(dac_data_valid), 64'd0);

    // Two-cycle latency of a single L=0 sample
    send(100);
    exp_q.push_back(8292);
    idle(1);
    chk("latency_cycle1_valid", 64'(dac_data_valid), 64'd0);
    idle(1);
    chk("latency_cycle2_valid", 64'(dac_data_valid), 64'd1);
    idle(1);
    chk("latency_cycle3_valid", 64'(dac_data_valid), 64'd0);

    // Back-to-back L=0 vectors at full throughput
    clips = 0;
    foreach (tbl[i]) begin
      @(negedge clk);
      data_in       = tbl[i].din;
      shift         = tbl[i].sh;
      data_in_valid = 1'b1;
      exp_q.push_back(tbl[i].exp);
      if (tbl[i].clip) clips++;
    end
    idle(4);
    shift = 6'd0;
    chk("table_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("table_sat_count", 64'(sat_count), SAT_EN ? 64'(clips) : 64'd0);

    // Four-sample block
    log2_avg = 4'd2;
    send(4);  idle(3);
    send(8);  idle(3);
    send(12); idle(3);
    chk("block_no_early_pulse", 64'(dac_data_valid), 64'd0);
    send(16);
    exp_q.push_back(8202);
    idle(4);

    // Enable drop loses the partial block
    send(1000);
    send(1000);
    @(negedge clk);
    data_in_valid = 1'b0;
    enable        = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    repeat (4) send(40);
    exp_q.push_back(8232);
    idle(4);

    // Mid-block change of log2_avg waits for the next block
    send(4);
    send(8);
    log2_avg = 4'd0;
    send(12);
    send(16);
    exp_q.push_back(8202);
    send(100);
    exp_q.push_back(8292);
    idle(4);
    chk("latch_queue_drained", 64'(exp_q.size()), 64'd0);

    // Result in stage 1 is discarded when enable falls
    send(500);
    @(negedge clk);
    data_in_valid = 1'b0;
    enable        = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    idle(3);
    chk("enable_drop_hold", 64'(dac_data), 64'd8292);

    // log2_avg above the maximum clamps to 256-sample blocks
    log2_avg = 4'd15;
    repeat (255) send(3);
    idle(3);
    chk("clamp_no_early_pulse", 64'(exp_q.size()), 64'd0);
    send(3);
    exp_q.push_back(8195);
    idle(4);
    chk("clamp_queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-pipeline and mid-block abandons in-flight data
    log2_avg = 4'd0;
    send(300);
    @(negedge clk);
    data_in_valid = 1'b0;
    reset_n       = 1'b0;
    #1;
    chk("reset_mid_dac", 64'(dac_data), 64'd8192);
    chk("reset_mid_sat", 64'(sat_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    chk("reset_mid_hold", 64'(dac_data), 64'd8192);
    log2_avg = 4'd2;
    send(1);
    send(2);
    @(negedge clk);
    data_in_valid = 1'b0;
    reset_n       = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) send(40);
    exp_q.push_back(8232);
    idle(4);

    // Saturation counting and clear priority
    log2_avg = 4'd0;
    send(20000);
    exp_q.push_back(16383);
    idle(3);
    chk("sat_count_1", 64'(sat_count), SAT_EN ? 64'd1 : 64'd0);
    send(-20000);
    exp_q.push_back(0);
    idle(3);
    chk("sat_count_2", 64'(sat_count), SAT_EN ? 64'd2 : 64'd0);
    send(20000);
    exp_q.push_back(16383);
    idle(1);
    @(negedge clk);
    clear_sat = 1'b1;
    @(negedge clk);
    clear_sat = 1'b0;
    chk("sat_clear_wins", 64'(sat_count), 64'd0);

    idle(5);
    chk("final_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_output_stage.md
DAC_OUTPUT_STAGE -- requirements
Module: dac_output_stage

Interface
REQ-001 Parameter DATA_IN_W, default 64: width of the signed processed input sample.
REQ-002 Parameter DAC_W, default 14: width of the DAC output code.
REQ-003 Parameter MAX_LOG2_AVG, default 8: largest supported log2 of the averaging block length.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port clk, input, 1: the single clock; every register SHALL be on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port enable, input, 1: general enable; when low, no samples are accepted.
REQ-008 Port data_in, input, DATA_IN_W: signed two's-complement processed sample.
REQ-009 Port data_in_valid, input, 1: data_in is valid this cycle; no backpressure.
REQ-010 Port log2_avg, input, 4: log2 of the averaging block length; values above MAX_LOG2_AVG SHALL be clamped to MAX_LOG2_AVG.
REQ-011 Port shift, input, 6: additional arithmetic right shift (gain) applied after averaging.
REQ-012 Port clear_sat, input, 1: synchronous clear of sat_count.
REQ-013 Port dac_data, output, DAC_W: offset-binary DAC code, held between updates.
REQ-014 Port dac_data_valid, output, 1: one-cycle pulse marking each new dac_data value.
REQ-015 Port sat_count, output, 32: number of saturated output codes.

Function
REQ-016 A sample SHALL be accepted only in a cycle where enable and data_in_valid are both 1.
REQ-017 On the first accepted sample of a block, the block SHALL latch log2_avg (after clamping) and shift; changes made mid-block SHALL take effect from the next block.
REQ-018 The accumulator SHALL be signed, DATA_IN_W+MAX_LOG2_AVG bits wide, and SHALL never overflow.
REQ-019 The sample counter SHALL count accepted samples; at the 2^L-th accepted sample (L = latched log2_avg), the stage-1 register SHALL capture (acc + data_in) >>> (L + latched shift), and acc and the counter SHALL restart at 0.
REQ-020 Stage 2 SHALL saturate the stage-1 result to [-2^(DAC_W-1), 2^(DAC_W-1)-1] and convert it to offset binary by adding 2^(DAC_W-1).
REQ-021 dac_data_valid SHALL pulse exactly 2 cycles after the clock edge that accepts the last sample of a block.
REQ-022 With L = 0, every accepted sample SHALL produce one output; back-to-back inputs SHALL give back-to-back output pulses at full throughput.
REQ-023 The arithmetic right shift SHALL round toward minus infinity; no rounding correction is applied.
REQ-024 When enable is low, acc and the counter SHALL clear to 0, and any result still in stages 1 or 2 SHALL be discarded without pulsing dac_data_valid; dac_data SHALL hold its last value.
REQ-025 A 2^L-sample block SHALL be counted only over contiguous enable-high time; samples accepted before an enable drop SHALL be lost.

Reset
REQ-026 While reset_n is low: dac_data = 2^(DAC_W-1) (midscale, 8192), dac_data_valid = 0, sat_count = 0, acc = 0, counter = 0, both pipeline stages invalid, latched L and shift = 0.
REQ-027 Reset asserted mid-block or mid-pipeline SHALL abandon all in-flight data with no output pulse.

Configuration
REQ-028 With macro DAC_OUTPUT_SAT_COUNT_EN defined, sat_count SHALL increment by 1 on each output pulse whose value was clipped.
REQ-029 With DAC_OUTPUT_SAT_COUNT_EN defined, sat_count SHALL stick at 0xFFFFFFFF once reached.
REQ-030 With DAC_OUTPUT_SAT_COUNT_EN defined, clear_sat SHALL zero sat_count on the next edge; if clear_sat and an increment occur in the same cycle, clear SHALL win and the result SHALL be 0.
REQ-031 Without DAC_OUTPUT_SAT_COUNT_EN, sat_count SHALL be constant 0 and clear_sat SHALL be ignored; all other behaviour SHALL be identical.

Structure
REQ-032 Package dac_output_pkg SHALL hold the DATA_IN_W, DAC_W and MAX_LOG2_AVG defaults, the derived accumulator width and the DAC_MIDSCALE constant.
REQ-033 Saturation plus offset-binary conversion (stage 2) SHALL be a sub-module named dac_saturator, with a registered output and a clipped flag.

Verification
REQ-034 Reset: hold reset_n low -> dac_data = 8192, dac_data_valid = 0, sat_count = 0; release with no input -> no pulse.
REQ-035 log2_avg = 0, shift = 0, input 100 -> one pulse 2 cycles later with dac_data = 8292.
REQ-036 log2_avg = 2, inputs 4, 8, 12, 16 -> no pulse after the first three; one pulse after the 4th with dac_data = 8202.
REQ-037 log2_avg = 0: input 20000 -> dac_data = 16383, sat_count = 1; then input -20000 -> dac_data = 0, sat_count = 2; pulse clear_sat together with a third clip -> sat_count = 0.
REQ-038 log2_avg = 2: two samples of 1000, enable low for 1 cycle, then four samples of 40 -> single pulse with dac_data = 8232.
REQ-039 log2_avg = 0, shift = 4: input -161 -> dac_data = 8181 (result -11).
